// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, FSM encoding and digit helper for the
//                digit-serial BCD adder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_if.sv
// ============================================================================
//  Module      : bcd_serial_add_ctrl_if
//  Description : Operand-source handshake and result bus of the serial adder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_serial_add_ctrl_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                cin;
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
//  Module      : bcd_digit_add
//  Description : Combinational single-digit BCD adder with decimal correction.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_add
    import bcd_pkg::*;
(
    input  wire logic [3:0] x,
    input  wire logic [3:0] y,
    input  wire logic       ci,
    output logic      [3:0] d,
    output logic            co
);

    logic [4:0] s;

    // Worst case 15+15+1 = 31 still fits in five bits.
    assign s = {1'b0, x} + {1'b0, y} + {4'd0, ci};

    always_comb begin
        d  = s[3:0];
        co = 1'b0;
        if (s > {1'b0, BCD_MAX}) begin
            d  = s[3:0] + BCD_ADJ;
            co = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
//  Module      : bcd_serial_add_ctrl
//  Description : Sequencer adding two packed-BCD operands one digit per clock,
//                least-significant digit first, through one shared digit adder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    bcd_serial_add_ctrl_if.slave   bus
);

    localparam int W    = 4 * NDIG;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, b_q, sum_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q, cout_q, err_q, busy_q, done_q;

    logic              load, step, finish, last;
    logic [3:0]        digit;
    logic              digit_co;
    logic [2*NDIG-1:0] nonbcd;
    logic              in_err;

    for (genvar g = 0; g < NDIG; g++) begin : g_err
        assign nonbcd[2*g]   = !is_bcd(bus.a[4*g +: 4]);
        assign nonbcd[2*g+1] = !is_bcd(bus.b[4*g +: 4]);
    end
    assign in_err = |nonbcd;

    assign last = (idx_q == IDXW'(NDIG - 1));

    bcd_digit_add u_digit (
        .x  (a_q[4*idx_q +: 4]),
        .y  (b_q[4*idx_q +: 4]),
        .ci (carry_q),
        .d  (digit),
        .co (digit_co)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (load) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= bus.cin;
                idx_q   <= '0;
                sum_q   <= '0;
                err_q   <= in_err;
                busy_q  <= 1'b1;
            end
            if (step) begin
                sum_q[4*idx_q +: 4] <= digit;
                carry_q             <= digit_co;
                if (!last) begin
                    idx_q <= idx_q + IDXW'(1);
                end
            end
            if (finish) begin
                cout_q <= digit_co;
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
//  Module      : tb_bcd_serial_add_ctrl
//  Description : Self-checking bench for the digit-serial BCD adder (NDIG=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: BCD -> integer, add, integer -> BCD.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output logic e);
        int va, vb, tot;
        va = 0; vb = 0; e = 1'b0; s = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) e = 1'b1;
            va = va * 10 + int'(a[4*i +: 4]);
            vb = vb * 10 + int'(b[4*i +: 4]);
        end
        tot = va + vb + int'(c);
        co  = (tot >= 10000);
        tot = tot % 10000;
        for (int i = 0; i < NDIG; i++) begin
            s[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
        end
    endtask

    task automatic do_op(input logic [15:0] a_in, input logic [15:0] b_in, input logic c_in,
                         input logic scramble);
        logic [15:0] es;
        logic        ec, ee;
        int          cyc;
        model(a_in, b_in, c_in, es, ec, ee);
        @(negedge clk);
        bus.a = a_in; bus.b = b_in; bus.cin = c_in; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            if (scramble) begin
                bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
            end
            check_eq("busy_run", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(NDIG));
        check_eq("busy_done", 32'(bus.busy), 32'd0);
        check_eq("err", 32'(bus.err), 32'(ee));
        if (!ee) begin
            check_eq("sum", 32'(bus.sum), 32'(es));
            check_eq("cout", 32'(bus.cout), 32'(ec));
        end
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(bus.done), 32'd0);
        if (!ee) check_eq("sum_hold", 32'(bus.sum), 32'(es));
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        int dones, first_done, last_done;
        logic [15:0] ra, rb;
        n_checks = 0; n_errors = 0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_sum",  32'(bus.sum),  32'd0);
        check_eq("rst_cout", 32'(bus.cout), 32'd0);
        check_eq("rst_err",  32'(bus.err),  32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        do_op(16'h9999, 16'h9999, 1'b1, 1'b1);
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        do_op(16'h0A00, 16'h0000, 1'b0, 1'b0);

        // start re-pulsed two cycles into RUN must be ignored
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'h4444; bus.b = 16'h3333; bus.cin = 1'b1; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                check_eq("ign_sum", 32'(bus.sum), 32'h6912);
            end
        end
        check_eq("ign_dones", 32'(dones), 32'd1);

        // start held high for 12 edges
        @(negedge clk);
        bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0; bus.start = 1'b1;
        dones = 0; first_done = -1; last_done = -1;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk); #1;
            if (i == 12) bus.start = 1'b0;
            if (bus.done) begin
                if (last_done >= 0) check_eq("hold_gap", 32'(i - last_done), 32'(NDIG + 1));
                else first_done = i;
                last_done = i;
                dones++;
                check_eq("hold_sum", 32'(bus.sum), 32'h0010);
            end
        end
        check_eq("hold_first", 32'(first_done), 32'(NDIG + 1));
        check_eq("hold_dones", 32'(dones), 32'd3);

        // reset mid-RUN, after an op that leaves cout=1
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check_eq("mrst_busy", 32'(bus.busy), 32'd0);
        check_eq("mrst_done", 32'(bus.done), 32'd0);
        check_eq("mrst_sum",  32'(bus.sum),  32'd0);
        check_eq("mrst_cout", 32'(bus.cout), 32'd0);
        check_eq("mrst_err",  32'(bus.err),  32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        rst_n = 1'b1;
        check_eq("mrst_nodone", 32'(dones), 32'd0);
        do_op(16'h2468, 16'h1357, 1'b1, 1'b0);

        // randomized operands, occasionally with non-BCD digits
        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd(); rb = rand_bcd();
            if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
            if ($urandom_range(0, 5) == 0) rb = 16'($urandom);
            do_op(ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
